// File: rtl/lsu_port_arbiter.sv
// lsu_port_arbiter: shares one LSU data port between the core (port 0) and debug/DMA (port 1)
module lsu_port_arbiter #(
  parameter int MAX_BURST = 4,
  parameter bit INIT_LAST = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req0,
  input  logic        i_lock0,
  input  logic [31:0] i_addr0,
  input  logic [31:0] i_wdata0,
  input  logic        i_wren0,
  input  logic [2:0]  i_memop0,
  input  logic        i_req1,
  input  logic        i_lock1,
  input  logic [31:0] i_addr1,
  input  logic [31:0] i_wdata1,
  input  logic        i_wren1,
  input  logic [2:0]  i_memop1,
  output logic        o_gnt0,
  output logic        o_gnt1,
  output logic        o_rvalid0,
  output logic        o_rvalid1,
  output logic [31:0] o_rdata0,
  output logic [31:0] o_rdata1,
  output logic [31:0] o_lsu_addr,
  output logic [31:0] o_lsu_wdata,
  output logic        o_lsu_wren,
  output logic [2:0]  o_lsu_memop,
  input  logic [31:0] i_lsu_rdata,
  output logic        o_busy
);
  localparam int BW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BEAT_MAX = BW'(MAX_BURST - 1);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t state, state_n;
  logic last, cont0, cont1, rd0, rd1, burst;
  logic [BW-1:0] beat, beat_n;
  // grant selection, lock tracking, burst counting and the LSU payload mux
  always_comb begin
    cont0 = state == OWN0 && i_req0 && i_lock0 && (beat < BEAT_MAX || !i_req1);
    cont1 = state == OWN1 && i_req1 && i_lock1 && (beat < BEAT_MAX || !i_req0);
    o_gnt0 = !i_rst && (cont0 || (!cont1 && i_req0 && (!i_req1 || last)));
    o_gnt1 = !i_rst && (cont1 || (!cont0 && i_req1 && (!i_req0 || !last)));
    state_n = o_gnt0 && i_lock0 ? OWN0 : o_gnt1 && i_lock1 ? OWN1 : IDLE;
    burst = (state == OWN0 && o_gnt0) || (state == OWN1 && o_gnt1);
    beat_n = burst ? (beat == BEAT_MAX ? beat : beat + 1'b1) : '0;
    rd0 = o_gnt0 && !i_wren0;
    rd1 = o_gnt1 && !i_wren1;
    o_lsu_addr = o_gnt0 ? i_addr0 : o_gnt1 ? i_addr1 : '0;
    o_lsu_wdata = o_gnt0 ? i_wdata0 : o_gnt1 ? i_wdata1 : '0;
    o_lsu_wren = o_gnt0 ? i_wren0 : o_gnt1 ? i_wren1 : 1'b0;
    o_lsu_memop = o_gnt0 ? i_memop0 : o_gnt1 ? i_memop1 : '0;
  end
  // lock state, round-robin pointer and burst beat register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      last <= INIT_LAST;
      beat <= '0;
    end else begin
      state <= state_n;
      beat <= beat_n;
      if (o_gnt0 || o_gnt1) last <= o_gnt1;
    end
  end
  // registered read response returned to the port that was granted a read
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rvalid0 <= 1'b0;
      o_rvalid1 <= 1'b0;
      o_rdata0 <= '0;
      o_rdata1 <= '0;
    end else begin
      o_rvalid0 <= rd0;
      o_rvalid1 <= rd1;
      if (rd0) o_rdata0 <= i_lsu_rdata;
      if (rd1) o_rdata1 <= i_lsu_rdata;
    end
  end
  assign o_busy = state != IDLE;
endmodule

// File: tb/tb_lsu_port_arbiter.sv
// tb_lsu_port_arbiter: directed checks of grants, bursts, LSU mux and read responses
module tb_lsu_port_arbiter;
  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req0, i_lock0, i_wren0, i_req1, i_lock1, i_wren1;
  logic [31:0] i_addr0, i_wdata0, i_addr1, i_wdata1;
  logic [2:0]  i_memop0, i_memop1;
  logic        o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_lsu_wren, o_busy;
  logic [31:0] o_rdata0, o_rdata1, o_lsu_addr, o_lsu_wdata, i_lsu_rdata;
  logic [2:0]  o_lsu_memop;
  logic [31:0] st_addr = 32'hFFFF_FFFF;
  logic [31:0] st_data = '0;
  logic [31:0] exp_rd0, exp_rd1;
  logic        wrote;
  int          checks = 0;
  int          failures = 0;

  lsu_port_arbiter dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req0(i_req0), .i_lock0(i_lock0), .i_addr0(i_addr0), .i_wdata0(i_wdata0),
    .i_wren0(i_wren0), .i_memop0(i_memop0),
    .i_req1(i_req1), .i_lock1(i_lock1), .i_addr1(i_addr1), .i_wdata1(i_wdata1),
    .i_wren1(i_wren1), .i_memop1(i_memop1),
    .o_gnt0(o_gnt0), .o_gnt1(o_gnt1), .o_rvalid0(o_rvalid0), .o_rvalid1(o_rvalid1),
    .o_rdata0(o_rdata0), .o_rdata1(o_rdata1),
    .o_lsu_addr(o_lsu_addr), .o_lsu_wdata(o_lsu_wdata), .o_lsu_wren(o_lsu_wren),
    .o_lsu_memop(o_lsu_memop), .i_lsu_rdata(i_lsu_rdata), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  // LSU stand-in: remembers the last store, otherwise reads back the inverted address
  always @(posedge i_clk) if (o_lsu_wren) begin
    st_addr <= o_lsu_addr;
    st_data <= o_lsu_wdata;
  end
  assign i_lsu_rdata = (o_lsu_addr == st_addr) ? st_data : ~o_lsu_addr;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return (wrote && a == 32'h2004) ? 32'hDEAD_BEEF : ~a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag, input logic eg0, input logic eg1);
    logic [31:0] ea, ew;
    logic [2:0] em;
    logic ewr;
    @(negedge i_clk);
    ea = eg0 ? i_addr0 : eg1 ? i_addr1 : 32'h0;
    ew = eg0 ? i_wdata0 : eg1 ? i_wdata1 : 32'h0;
    em = eg0 ? i_memop0 : eg1 ? i_memop1 : 3'h0;
    ewr = eg0 ? i_wren0 : eg1 ? i_wren1 : 1'b0;
    chk({tag, "_gnt0"}, 32'(o_gnt0), 32'(eg0));
    chk({tag, "_gnt1"}, 32'(o_gnt1), 32'(eg1));
    chk({tag, "_addr"}, o_lsu_addr, ea);
    chk({tag, "_wdata"}, o_lsu_wdata, ew);
    chk({tag, "_memop"}, 32'(o_lsu_memop), 32'(em));
    chk({tag, "_wren"}, 32'(o_lsu_wren), 32'(ewr));
    @(posedge i_clk);
    #1;
    if (eg0 && !i_wren0) exp_rd0 = rd_model(i_addr0);
    if (eg1 && !i_wren1) exp_rd1 = rd_model(i_addr1);
    chk({tag, "_rvalid0"}, 32'(o_rvalid0), 32'(eg0 && !i_wren0));
    chk({tag, "_rvalid1"}, 32'(o_rvalid1), 32'(eg1 && !i_wren1));
    chk({tag, "_rdata0"}, o_rdata0, exp_rd0);
    chk({tag, "_rdata1"}, o_rdata1, exp_rd1);
  endtask

  initial begin
    bit [8:0] pat3;
    i_rst = 1'b1;
    wrote = 1'b0;
    exp_rd0 = '0;
    exp_rd1 = '0;
    i_req0 = 1'b1; i_lock0 = 1'b0; i_wren0 = 1'b1; i_addr0 = 32'h100;
    i_wdata0 = 32'h1111_0000; i_memop0 = 3'b010;
    i_req1 = 1'b1; i_lock1 = 1'b0; i_wren1 = 1'b0; i_addr1 = 32'h200;
    i_wdata1 = 32'h2222_0000; i_memop1 = 3'b100;
    // reset holds grants and store enable low despite both requests
    #12;
    chk("rst_gnt0", 32'(o_gnt0), 32'd0);
    chk("rst_gnt1", 32'(o_gnt1), 32'd0);
    chk("rst_wren", 32'(o_lsu_wren), 32'd0);
    chk("rst_rvalid0", 32'(o_rvalid0), 32'd0);
    chk("rst_rdata0", o_rdata0, 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    @(posedge i_clk);
    #1;
    i_wren0 = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    // round-robin reads; port 0 wins the first tie after reset
    for (int c = 0; c < 6; c++) begin
      i_addr0 = 32'h100 + 32'(c * 4);
      i_addr1 = 32'h200 + 32'(c * 4);
      tick($sformatf("rr%0d", c), c % 2 == 0, c % 2 == 1);
    end
    // locked burst on port 0 against a waiting port 1
    pat3 = 9'b0_0001_0000;
    i_lock0 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      i_addr0 = 32'h300 + 32'(i * 4);
      tick($sformatf("burst%0d", i), !pat3[i], pat3[i]);
      if (i == 4) chk("burst_busy_released", 32'(o_busy), 32'd0);
    end
    chk("burst_busy", 32'(o_busy), 32'd1);
    i_req0 = 1'b0; i_lock0 = 1'b0; i_req1 = 1'b0;
    tick("idle", 1'b0, 1'b0);
    chk("idle_busy", 32'(o_busy), 32'd0);
    // store from port 1, then load the same word on port 0
    i_req1 = 1'b1; i_wren1 = 1'b1; i_addr1 = 32'h2004; i_wdata1 = 32'hDEAD_BEEF; i_memop1 = 3'b010;
    tick("store", 1'b0, 1'b1);
    wrote = 1'b1;
    i_req1 = 1'b0; i_wren1 = 1'b0;
    i_req0 = 1'b1; i_addr0 = 32'h2004;
    tick("load", 1'b1, 1'b0);
    chk("load_data", o_rdata0, 32'hDEAD_BEEF);
    // port 1 locks with an idle competitor, then port 0 arrives after saturation
    i_req0 = 1'b0;
    i_req1 = 1'b1; i_lock1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      i_addr1 = 32'h400 + 32'(i * 4);
      tick($sformatf("lock1_%0d", i), 1'b0, 1'b1);
    end
    chk("lock1_busy", 32'(o_busy), 32'd1);
    i_req0 = 1'b1; i_addr0 = 32'h500;
    tick("lock1_preempt", 1'b1, 1'b0);
    // reset in the middle of a port 0 burst
    i_req1 = 1'b0; i_lock1 = 1'b0;
    i_lock0 = 1'b1; i_addr0 = 32'h600;
    tick("mid0", 1'b1, 1'b0);
    i_addr0 = 32'h604;
    tick("mid1", 1'b1, 1'b0);
    i_rst = 1'b1;
    #1;
    exp_rd0 = '0;
    exp_rd1 = '0;
    chk("midrst_rvalid0", 32'(o_rvalid0), 32'd0);
    chk("midrst_rdata0", o_rdata0, 32'd0);
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_gnt0", 32'(o_gnt0), 32'd0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    #1;
    chk("post_busy", 32'(o_busy), 32'd0);
    i_req1 = 1'b1; i_addr1 = 32'h700;
    for (int i = 0; i < 5; i++) begin
      i_addr0 = 32'h800 + 32'(i * 4);
      tick($sformatf("post%0d", i), i != 4, i == 4);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
